// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver phases and
// the ALU command controller state encoding.
package uart_pkg;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_STOP    = 3'd3,
    RX_CLEANUP = 3'd4
  } uart_rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE    = 3'd0,
    TX_START   = 3'd1,
    TX_DATA    = 3'd2,
    TX_STOP    = 3'd3,
    TX_CLEANUP = 3'd4
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/uart_timeout.sv
// Saturating inter-byte watchdog; flags expiry
// once the idle count reaches TIMEOUT_CYCLES-1.
module uart_timeout
  import uart_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic i_Clock,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  // idle cycle count, held at all-ones instead of wrapping
  always_ff @(posedge i_Clock) begin
    if (!i_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

  assign expired = enable &&
    (count == TIMEOUT_CYCLES - 16'd1);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects A, B and opcode bytes from the UART,
// runs the ALU and sends the result byte back.
module uart_alu_ctrl
  import uart_pkg::*;
#(
  parameter int          Bits           = 8,
  parameter int          OP_BITS        = 6,
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic               i_Clock,
  input  logic               i_reset,
  input  logic               i_Rx_Done,
  input  logic [Bits-1:0]    i_Rx_Byte,
  input  logic [Bits-1:0]    i_Alu_Result,
  input  logic               i_Tx_Done,
  output logic [Bits-1:0]    o_A,
  output logic [Bits-1:0]    o_B,
  output logic [OP_BITS-1:0] o_Op,
  output logic               o_Tx_Start,
  output logic [Bits-1:0]    o_Tx_Byte,
  output logic               o_busy,
  output logic               o_error,
  output logic               o_overrun
);

  ctrl_state_t state, state_n;

  logic [Bits-1:0]    a_n, b_n, txb_n;
  logic [OP_BITS-1:0] op_n;
  logic               txs_n, err_n, ovr_n;
  logic               in_wait, expired;

  assign in_wait = (state == S_WAIT_B) ||
                   (state == S_WAIT_OP);

  uart_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_Clock(i_Clock),
    .i_reset(i_reset),
    .clear  (!in_wait || i_Rx_Done),
    .enable (in_wait),
    .expired(expired)
  );

  assign o_busy = (state != S_WAIT_A);

  // next state and next register values
  always_comb begin
    state_n = state;
    a_n     = o_A;
    b_n     = o_B;
    op_n    = o_Op;
    txb_n   = o_Tx_Byte;
    txs_n   = 1'b0;
    err_n   = 1'b0;
    ovr_n   = 1'b0;
    unique case (state)
      S_WAIT_A: begin
        if (i_Rx_Done) begin
          a_n     = i_Rx_Byte;
          state_n = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (i_Rx_Done) begin
          b_n     = i_Rx_Byte;
          state_n = S_WAIT_OP;
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (i_Rx_Done) begin
          op_n    = i_Rx_Byte[OP_BITS-1:0];
          state_n = S_EXEC;
        end else if (expired) begin
          err_n   = 1'b1;
          state_n = S_WAIT_A;
        end
      end
      S_EXEC: begin
        txb_n   = i_Alu_Result;
        ovr_n   = i_Rx_Done;
        state_n = S_SEND;
      end
      S_SEND: begin
        txs_n   = 1'b1;
        ovr_n   = i_Rx_Done;
        state_n = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        ovr_n = i_Rx_Done;
        if (i_Tx_Done) state_n = S_WAIT_A;
      end
      default: begin
        state_n = S_WAIT_A;
      end
    endcase
  end

  // state and all registered outputs
  always_ff @(posedge i_Clock) begin
    if (!i_reset) begin
      state      <= S_WAIT_A;
      o_A        <= '0;
      o_B        <= '0;
      o_Op       <= '0;
      o_Tx_Byte  <= '0;
      o_Tx_Start <= 1'b0;
      o_error    <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      state      <= state_n;
      o_A        <= a_n;
      o_B        <= b_n;
      o_Op       <= op_n;
      o_Tx_Byte  <= txb_n;
      o_Tx_Start <= txs_n;
      o_error    <= err_n;
      o_overrun  <= ovr_n;
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl with a
// frame-level reference model and toy ALU.
module tb_uart_alu_ctrl;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_Rx_Done;
  logic [7:0] i_Rx_Byte;
  logic [7:0] i_Alu_Result;
  logic       i_Tx_Done;
  logic [7:0] o_A, o_B, o_Tx_Byte;
  logic [5:0] o_Op;
  logic       o_Tx_Start, o_busy;
  logic       o_error, o_overrun;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } exp_t;

  exp_t tx_q[$];
  int   err_q[$];
  int   ovr_q[$];

  function automatic logic [7:0] alu_f(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [5:0] op
  );
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  assign i_Alu_Result = alu_f(o_A, o_B, o_Op);

  uart_alu_ctrl #(
    .Bits(8),
    .OP_BITS(6),
    .TIMEOUT_CYCLES(16'd20)
  ) dut (
    .i_Clock     (clk),
    .i_reset     (i_reset),
    .i_Rx_Done   (i_Rx_Done),
    .i_Rx_Byte   (i_Rx_Byte),
    .i_Alu_Result(i_Alu_Result),
    .i_Tx_Done   (i_Tx_Done),
    .o_A         (o_A),
    .o_B         (o_B),
    .o_Op        (o_Op),
    .o_Tx_Start  (o_Tx_Start),
    .o_Tx_Byte   (o_Tx_Byte),
    .o_busy      (o_busy),
    .o_error     (o_error),
    .o_overrun   (o_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // monitor: every output pulse must match the
  // front of its expectation queue
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_Tx_Start) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = tx_q.pop_front();
          chk("tx_cycle", cyc, e.cyc);
          chk("tx_byte", {24'd0, o_Tx_Byte},
              {24'd0, e.res});
          chk("tx_a", {24'd0, o_A}, {24'd0, e.a});
          chk("tx_b", {24'd0, o_B}, {24'd0, e.b});
          chk("tx_op", {26'd0, o_Op},
              {26'd0, e.op});
        end
      end
      if (o_error) begin
        if (err_q.size() == 0)
          chk("err_unexpected", 1, 0);
        else
          chk("err_cycle", cyc, err_q.pop_front());
      end
      if (o_overrun) begin
        if (ovr_q.size() == 0)
          chk("ovr_unexpected", 1, 0);
        else
          chk("ovr_cycle", cyc, ovr_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(
    input  logic [7:0] b,
    output int         edge_n
  );
    i_Rx_Done = 1'b1;
    i_Rx_Byte = b;
    tick();
    edge_n    = cyc;
    i_Rx_Done = 1'b0;
    i_Rx_Byte = 8'($urandom);
  endtask

  task automatic pulse_tx_done();
    i_Tx_Done = 1'b1;
    tick();
    i_Tx_Done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a"}, {24'd0, o_A}, 0);
    chk({tag, "_b"}, {24'd0, o_B}, 0);
    chk({tag, "_op"}, {26'd0, o_Op}, 0);
    chk({tag, "_txb"}, {24'd0, o_Tx_Byte}, 0);
    chk({tag, "_txs"}, {31'd0, o_Tx_Start}, 0);
    chk({tag, "_busy"}, {31'd0, o_busy}, 0);
    chk({tag, "_err"}, {31'd0, o_error}, 0);
    chk({tag, "_ovr"}, {31'd0, o_overrun}, 0);
  endtask

  // mode 0 plain, 1 overrun in EXEC,
  // 2 overrun in WAIT_TX, 3 stray Tx_Done in EXEC
  task automatic frame(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] ob,
    input int         g1,
    input int         g2,
    input int         mode
  );
    int   n, m, k;
    exp_t e;
    send(a, n);
    idle(g1);
    send(b, n);
    idle(g2);
    send(ob, n);
    e.cyc = n + 2;
    e.a   = a;
    e.b   = b;
    e.op  = ob[5:0];
    e.res = alu_f(a, b, ob[5:0]);
    tx_q.push_back(e);
    if (mode == 1) begin
      send(8'hAA, m);
      ovr_q.push_back(m);
    end else if (mode == 3) begin
      pulse_tx_done();
    end
    k = 0;
    while (!o_Tx_Start && k < 10) begin
      tick();
      k++;
    end
    chk("tx_start_wait", {31'd0, k < 10}, 1);
    if (mode == 2) begin
      send(8'hAA, m);
      ovr_q.push_back(m);
      chk("tx_byte_hold", {24'd0, o_Tx_Byte},
          {24'd0, e.res});
    end
    idle($urandom_range(0, 3));
    pulse_tx_done();
    chk("idle_after_tx", {31'd0, o_busy}, 0);
  endtask

  initial begin
    int n;
    logic [7:0] ops [6];
    ops[0] = 8'h20; ops[1] = 8'h22;
    ops[2] = 8'h24; ops[3] = 8'h25;
    ops[4] = 8'h26; ops[5] = 8'h3F;

    i_reset   = 1'b0;
    i_Rx_Done = 1'b0;
    i_Rx_Byte = 8'h00;
    i_Tx_Done = 1'b0;
    idle(3);
    chk_reset_vals("rst");
    i_reset = 1'b1;
    mon_en  = 1'b1;
    idle(2);

    frame(8'h05, 8'h03, 8'h20, 0, 0, 0);
    chk("add_result", {24'd0, o_Tx_Byte}, 8);

    send(8'h05, n);
    err_q.push_back(n + 20);
    idle(25);
    chk("busy_after_to", {31'd0, o_busy}, 0);
    frame(8'h07, 8'h02, 8'h22, 1, 1, 0);
    chk("sub_result", {24'd0, o_Tx_Byte}, 5);

    send(8'h11, n);
    send(8'h22, n);
    err_q.push_back(n + 20);
    idle(25);

    frame(8'h09, 8'h04, 8'h20, 19, 19, 0);

    send(8'h30, n);
    send(8'h10, n);
    send(8'hE2, n);
    chk("op_mask", {26'd0, o_Op}, 32'h22);
    tx_q.push_back('{n + 2, 8'h30, 8'h10,
                     6'h22, 8'h20});
    idle(3);
    pulse_tx_done();

    frame(8'h40, 8'h01, 8'h25, 0, 2, 2);

    send(8'h12, n);
    send(8'h34, n);
    send(8'h20, n);
    i_reset = 1'b0;
    tick();
    chk_reset_vals("rst_exec");
    i_reset = 1'b1;
    idle(4);

    send(8'h12, n);
    send(8'h34, n);
    send(8'h20, n);
    tick();
    i_reset = 1'b0;
    tick();
    chk("rst_send_txs", {31'd0, o_Tx_Start}, 0);
    chk("rst_send_busy", {31'd0, o_busy}, 0);
    i_reset = 1'b1;
    idle(4);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ob;
      ob = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0)
        ob = 8'($urandom);
      else
        ob[7:6] = 2'($urandom);
      frame(8'($urandom), 8'($urandom), ob,
            $urandom_range(0, 8),
            $urandom_range(0, 8),
            $urandom_range(0, 3));
    end

    idle(5);
    chk("tx_q_empty", tx_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    chk("ovr_q_empty", ovr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
